// File: rtl/pir_motion_ctrl.sv
// Multi-channel PIR motion detector: per-channel synchronizer, debounce/hold FSM,
// combined LED output and a saturating detection counter.
module pir_motion_ctrl #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned HOLD_CYC     = 25000000,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               hwclk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_CH-1:0]    pir_in,
    input  logic               count_clr,
    output logic [N_CH-1:0]    motion,
    output logic [N_CH-1:0]    motion_evt,
    output logic               led_out,
    output logic [COUNT_W-1:0] event_count
);

    localparam int unsigned DbW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned SumW  = COUNT_W + 5;

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYC - 1);
    localparam logic [SumW-1:0]  CntMax   = SumW'({COUNT_W{1'b1}});

    typedef enum logic [1:0] {StIdle, StQual, StActive} state_e;

    logic [N_CH-1:0]    sync_q [SYNC_STAGES];
    logic [N_CH-1:0]    sync_d [SYNC_STAGES];
    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [DbW-1:0]     db_q [N_CH];
    logic [DbW-1:0]     db_d [N_CH];
    logic [HoldW-1:0]   hold_q [N_CH];
    logic [HoldW-1:0]   hold_d [N_CH];
    logic [N_CH-1:0]    motion_q, motion_d;
    logic [N_CH-1:0]    evt_q, evt_d;
    logic               led_q, led_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]    s;
    logic [SumW-1:0]    sum;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = pir_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        evt_d    = '0;
        motion_d = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_d[ch] = state_q[ch];
            db_d[ch]    = db_q[ch];
            hold_d[ch]  = hold_q[ch];
            if (!en) begin
                state_d[ch] = StIdle;
                db_d[ch]    = '0;
                hold_d[ch]  = '0;
            end else begin
                unique case (state_q[ch])
                    StIdle: begin
                        if (s[ch]) begin
                            if (DEBOUNCE_CYC == 1) begin
                                state_d[ch] = StActive;
                                hold_d[ch]  = HoldLoad;
                                evt_d[ch]   = 1'b1;
                            end else begin
                                state_d[ch] = StQual;
                                db_d[ch]    = DbW'(1);
                            end
                        end
                    end
                    StQual: begin
                        if (!s[ch]) begin
                            state_d[ch] = StIdle;
                            db_d[ch]    = '0;
                        end else if (db_q[ch] == DbLast) begin
                            // This sample is the DEBOUNCE_CYC-th consecutive high one.
                            state_d[ch] = StActive;
                            db_d[ch]    = '0;
                            hold_d[ch]  = HoldLoad;
                            evt_d[ch]   = 1'b1;
                        end else begin
                            db_d[ch] = db_q[ch] + DbW'(1);
                        end
                    end
                    StActive: begin
                        if (s[ch]) begin
                            hold_d[ch] = HoldLoad;
                        end else if (hold_q[ch] == '0) begin
                            state_d[ch] = StIdle;
                        end else begin
                            hold_d[ch] = hold_q[ch] - HoldW'(1);
                        end
                    end
                    default: begin
                        state_d[ch] = StIdle;
                        db_d[ch]    = '0;
                        hold_d[ch]  = '0;
                    end
                endcase
            end
            motion_d[ch] = (state_d[ch] == StActive);
        end
        led_d = |motion_d;
    end

    always_comb begin
        sum = SumW'(cnt_q);
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            sum = sum + SumW'(evt_q[ch]);
        end
        if (count_clr) begin
            cnt_d = '0;
        end else if (sum > CntMax) begin
            cnt_d = {COUNT_W{1'b1}};
        end else begin
            cnt_d = sum[COUNT_W-1:0];
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= StIdle;
                db_q[ch]    <= '0;
                hold_q[ch]  <= '0;
            end
            motion_q <= '0;
            evt_q    <= '0;
            led_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                db_q[ch]    <= db_d[ch];
                hold_q[ch]  <= hold_d[ch];
            end
            motion_q <= motion_d;
            evt_q    <= evt_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
        end
    end

    assign motion      = motion_q;
    assign motion_evt  = evt_q;
    assign led_out     = led_q;
    assign event_count = cnt_q;

endmodule

// File: tb/tb_pir_motion_ctrl.sv
// Directed bench for pir_motion_ctrl with N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYC=4,
// HOLD_CYC=8, COUNT_W=4.
module tb_pir_motion_ctrl;

    logic       hwclk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] pir_in;
    logic       count_clr;
    logic [3:0] motion;
    logic [3:0] motion_evt;
    logic       led_out;
    logic [3:0] event_count;

    int total = 0;
    int bad   = 0;

    always #5 hwclk = ~hwclk;

    pir_motion_ctrl #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (8),
        .COUNT_W     (4)
    ) dut (
        .hwclk      (hwclk),
        .rst        (rst),
        .en         (en),
        .pir_in     (pir_in),
        .count_clr  (count_clr),
        .motion     (motion),
        .motion_evt (motion_evt),
        .led_out    (led_out),
        .event_count(event_count)
    );

    typedef struct {
        logic [3:0] pir;
        logic [3:0] mot;
        logic [3:0] evt;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    task automatic add(input int n, input logic [3:0] p, input logic [3:0] m,
                       input logic [3:0] e, input logic [3:0] c);
        repeat (n) vecs.push_back('{pir: p, mot: m, evt: e, cnt: c});
    endtask

    // Raise pattern, expect a detection with all pattern bits pulsing together,
    // optionally clear the counter on the pulse edge, then release and wait for idle.
    task automatic detect(input logic [3:0] pat, input logic clr, input logic [3:0] exp_cnt);
        pir_in = pat;
        for (int i = 0; i < 12 && motion !== pat; i++) step();
        chk("detect_motion", motion, pat);
        chk("detect_evt", motion_evt, pat);
        count_clr = clr;
        step();
        count_clr = 1'b0;
        chk("detect_count", event_count, exp_cnt);
        chk("detect_evt_single", motion_evt, 4'h0);
        pir_in = 4'h0;
        for (int i = 0; i < 30 && motion !== 4'h0; i++) step();
        chk("release_idle", motion, 4'h0);
        chk("release_count", event_count, exp_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        pir_in    = 4'h0;
        count_clr = 1'b0;
        #12;
        chk("rst_motion", motion, 4'h0);
        chk("rst_evt", motion_evt, 4'h0);
        chk("rst_led", led_out, 1'b0);
        chk("rst_count", event_count, 4'h0);
        rst = 1'b0;
        en  = 1'b1;
        step();

        // Basic detect on ch0, glitch on ch1, then retrigger/hold on ch0.
        add(3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(5, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 4'h1, 4'h0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h1);
        add(3, 4'h3, 4'h1, 4'h0, 4'h1);
        add(4, 4'h1, 4'h1, 4'h0, 4'h1);
        add(5, 4'h0, 4'h1, 4'h0, 4'h1);
        add(1, 4'h1, 4'h1, 4'h0, 4'h1);
        add(9, 4'h0, 4'h1, 4'h0, 4'h1);
        add(2, 4'h0, 4'h0, 4'h0, 4'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            pir_in = vecs[i].pir;
            step();
            chk($sformatf("vec%0d_motion", i), motion, vecs[i].mot);
            chk($sformatf("vec%0d_evt", i), motion_evt, vecs[i].evt);
            chk($sformatf("vec%0d_led", i), led_out, vecs[i].mot != 4'h0);
            chk($sformatf("vec%0d_count", i), event_count, vecs[i].cnt);
        end

        // Simultaneous four-channel events walking the counter into saturation.
        detect(4'hF, 1'b0, 4'd5);
        detect(4'hF, 1'b0, 4'd9);
        detect(4'hF, 1'b0, 4'd13);
        detect(4'hF, 1'b0, 4'd15);
        detect(4'hF, 1'b0, 4'd15);
        // Clear wins over a same-cycle event.
        detect(4'h1, 1'b1, 4'd0);

        // Reset mid-ACTIVE aborts at once; requalification needs the full latency.
        detect(4'h2, 1'b0, 4'd1);
        pir_in = 4'h1;
        for (int i = 0; i < 12 && motion !== 4'h1; i++) step();
        chk("pre_rst_active", motion, 4'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_motion", motion, 4'h0);
        chk("async_rst_evt", motion_evt, 4'h0);
        chk("async_rst_led", led_out, 1'b0);
        chk("async_rst_count", event_count, 4'h0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("requal%0d_motion", i), motion, 4'h0);
            chk($sformatf("requal%0d_evt", i), motion_evt, 4'h0);
        end
        step();
        chk("requal_motion", motion, 4'h1);
        chk("requal_evt", motion_evt, 4'h1);
        step();
        chk("requal_count", event_count, 4'd1);

        // One-cycle enable drop while active with input held high.
        en = 1'b0;
        step();
        en = 1'b1;
        chk("en_off_motion", motion, 4'h0);
        chk("en_off_evt", motion_evt, 4'h0);
        chk("en_off_led", led_out, 1'b0);
        chk("en_off_count", event_count, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("en_requal%0d_motion", i), motion, 4'h0);
        end
        step();
        chk("en_redetect_motion", motion, 4'h1);
        chk("en_redetect_evt", motion_evt, 4'h1);
        step();
        chk("en_redetect_count", event_count, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
